// File: rtl/elixirchip_es1_spu_chk_pkg.sv
// Shared types and helpers for the SPU operator result checkers.
// Counter arithmetic is done at a fixed maximum width and sliced by the user.
package elixirchip_es1_spu_chk_pkg;

  localparam int CNT_MAX_BITS = 64;

  typedef logic [CNT_MAX_BITS-1:0] cnt_max_t;

  function automatic cnt_max_t sat_inc(
    input cnt_max_t v,
    input cnt_max_t lim
  );
    return (v >= lim) ? v : v + cnt_max_t'(1);
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_cke_delay.sv
// cke-gated reference delay line: data plus a known bit per stage.
// Stage 0 loads on i_load; known bits only clear on reset.
module elixirchip_es1_spu_cke_delay #(
  parameter int  LATENCY = 1,
  parameter type data_t  = logic [7:0]
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  cke,
  input  logic  i_load,
  input  data_t i_data,
  output data_t o_data,
  output logic  o_known
);

  data_t              r_data [LATENCY];
  logic [LATENCY-1:0] r_known;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_data[i] <= '0;
      end
      r_known <= '0;
    end else if (cke) begin
      if (i_load) begin
        r_data[0]  <= i_data;
        r_known[0] <= 1'b1;
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_data[i]  <= r_data[i-1];
        r_known[i] <= r_known[i-1];
      end
    end
  end

  assign o_data  = r_data[LATENCY-1];
  assign o_known = r_known[LATENCY-1];

endmodule

// File: rtl/elixirchip_es1_spu_op_nand_checker.sv
// Result checker for the SPU NAND operator: rebuilds the expected result
// through a cke-gated model and keeps match/error counters plus first-error capture.
module elixirchip_es1_spu_op_nand_checker
  import elixirchip_es1_spu_chk_pkg::*;
#(
  parameter int  LATENCY    = 1,
  parameter int  DATA_BITS  = 8,
  parameter type data_t     = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA = '1,
  parameter int  COUNT_BITS = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cke,
  input  data_t                 s_data0,
  input  data_t                 s_data1,
  input  logic                  s_clear,
  input  logic                  s_valid,
  input  data_t                 m_data,
  input  logic                  err_clear,
  output logic                  chk_valid,
  output logic                  chk_error,
  output logic                  err_sticky,
  output logic [COUNT_BITS-1:0] match_count,
  output logic [COUNT_BITS-1:0] err_count,
  output data_t                 first_exp,
  output data_t                 first_got,
  output logic [COUNT_BITS-1:0] first_cycle
);

  typedef logic [COUNT_BITS-1:0] count_t;

  if (LATENCY < 1) begin : g_lat_chk
    $error("LATENCY must be >= 1");
  end
  if (COUNT_BITS > CNT_MAX_BITS || COUNT_BITS < 1) begin : g_cnt_chk
    $error("COUNT_BITS out of range");
  end

  localparam cnt_max_t CNT_LIM = cnt_max_t'({COUNT_BITS{1'b1}});

  logic     w_load;
  data_t    w_ref;
  data_t    w_tail;
  logic     w_known;
  logic     w_cmp;
  logic     w_mis;
  cnt_max_t w_mc_inc;
  cnt_max_t w_ec_inc;

  logic   r_chk_valid;
  logic   r_chk_error;
  logic   r_sticky;
  count_t r_match;
  count_t r_err;
  count_t r_cycle;
  data_t  r_fexp;
  data_t  r_fgot;
  count_t r_fcyc;

  // clear takes priority over valid when loading the model head
  assign w_load = s_clear | s_valid;
  assign w_ref  = s_clear ? CLEAR_DATA : ~(s_data0 & s_data1);

  elixirchip_es1_spu_cke_delay #(
    .LATENCY (LATENCY),
    .data_t  (data_t)
  ) u_ref (
    .clk     (clk),
    .reset_n (reset_n),
    .cke     (cke),
    .i_load  (w_load),
    .i_data  (w_ref),
    .o_data  (w_tail),
    .o_known (w_known)
  );

  assign w_cmp    = cke & w_known;
  assign w_mis    = w_cmp && (m_data != w_tail);
  assign w_mc_inc = sat_inc(cnt_max_t'(r_match), CNT_LIM);
  assign w_ec_inc = sat_inc(cnt_max_t'(r_err), CNT_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chk_valid <= 1'b0;
      r_chk_error <= 1'b0;
      r_sticky    <= 1'b0;
      r_match     <= '0;
      r_err       <= '0;
      r_cycle     <= '0;
      r_fexp      <= '0;
      r_fgot      <= '0;
      r_fcyc      <= '0;
    end else begin
      r_chk_valid <= w_cmp;
      r_chk_error <= w_mis & ~err_clear;
      if (cke) begin
        r_cycle <= r_cycle + count_t'(1);
      end
      // a clear coinciding with a compare discards that compare's result
      if (err_clear) begin
        r_sticky <= 1'b0;
        r_match  <= '0;
        r_err    <= '0;
        r_fexp   <= '0;
        r_fgot   <= '0;
        r_fcyc   <= '0;
      end else if (w_mis) begin
        r_err <= w_ec_inc[COUNT_BITS-1:0];
        if (!r_sticky) begin
          r_sticky <= 1'b1;
          r_fexp   <= w_tail;
          r_fgot   <= m_data;
          r_fcyc   <= r_cycle;
        end
      end else if (w_cmp) begin
        r_match <= w_mc_inc[COUNT_BITS-1:0];
      end
    end
  end

  assign chk_valid   = r_chk_valid;
  assign chk_error   = r_chk_error;
  assign err_sticky  = r_sticky;
  assign match_count = r_match;
  assign err_count   = r_err;
  assign first_exp   = r_fexp;
  assign first_got   = r_fgot;
  assign first_cycle = r_fcyc;

endmodule
